transport_tx: RTL

//  Transmit half of the transport layer, directly downstream of session.

---
 rtl/transport_tx_pkg.sv | 36 +++
 rtl/transport_tx_if.sv | 25 ++
 rtl/transport_tx_csum.sv | 24 ++
 rtl/transport_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/transport_tx_pkg.sv
// Shared transport-layer definitions: command/header encodings, the frame FSM
// states (also used by transport_rx) and the header layout.
package transport_tx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 6;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_VOICE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam logic [1:0] TYPE_CTRL  = 2'b01;
  localparam logic [1:0] TYPE_VOICE = 2'b10;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    IDLE, COLLECT, SYNC, HDR, DST, SRC, PAY_HI, PAY_LO, CSUM
  } txState_e;

  typedef struct packed {
    logic [1:0] pktType;
    logic [5:0] len;
  } hdr_t;

  // Header length field counts payload bytes, i.e. two per word.
  function automatic hdr_t makeHdr(input logic [1:0] pktType, input logic [CNT_W-1:0] count);
    hdr_t h;
    h.pktType = pktType;
    h.len     = {count[CNT_W-2:0], 1'b0};
    return h;
  endfunction

endpackage

// File: rtl/transport_tx_if.sv
// Session-to-transport word interface plus the byte link toward the PHY.
interface transport_tx_if;
  import transport_tx_pkg::*;

  logic [1:0]        cmd;
  logic [WORD_W-1:0] dataIn;
  logic [BYTE_W-1:0] phoneNum;
  logic [BYTE_W-1:0] selfNum;
  logic              transportBusy;
  logic [BYTE_W-1:0] txData;
  logic              txValid;
  logic              txReady;
  logic              pktSent;

  modport master (
    output cmd, dataIn, phoneNum, selfNum, txReady,
    input  transportBusy, txData, txValid, pktSent
  );

  modport slave (
    input  cmd, dataIn, phoneNum, selfNum, txReady,
    output transportBusy, txData, txValid, pktSent
  );

endinterface

// File: rtl/transport_tx_csum.sv
// 8-bit running byte sum; negSum_c is the byte that brings the total to zero.
module transport_tx_csum
  import transport_tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              addEn,
  input  logic [BYTE_W-1:0] byteIn,
  output logic [BYTE_W-1:0] sum,
  output logic [BYTE_W-1:0] negSum_c
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum <= '0;
    end else if (addEn) begin
      sum <= sum + byteIn;
    end
  end

  assign negSum_c = -sum;

endmodule

// File: rtl/transport_tx.sv
// Transport TX: collects session words and frames them as
// SYNC, HDR, DST, SRC, payload (MSB first), CSUM on a valid/ready byte link.
module transport_tx
  import transport_tx_pkg::*;
#(
  parameter int unsigned       PKT_WORDS = 8,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  transport_tx_if.slave bus
);

  localparam int unsigned      IDX_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_WORDS);

  txState_e          state, stateNext;
  logic [CNT_W-1:0]  count, countNext;
  logic [CNT_W-1:0]  idx, idxNext;
  logic [1:0]        pktType, typeNext;
  logic [BYTE_W-1:0] phoneLatch, selfLatch;
  logic [BYTE_W-1:0] txData, txDataNext;
  logic              txValid, txValidNext;
  logic              pktSent, pktSentNext;
  logic              busy;
  logic              loadFrame, storeWord, csumClr, csumAdd, handshake;
  logic [BYTE_W-1:0] csumSum, csumNeg;
  logic [WORD_W-1:0] wordBuf [PKT_WORDS];
  logic [WORD_W-1:0] curWord;

  assign handshake = txValid && bus.txReady;
  assign curWord   = wordBuf[IDX_W'(idx)];

  transport_tx_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .clr      (csumClr),
    .addEn    (csumAdd),
    .byteIn   (txDataNext),
    .sum      (csumSum),
    .negSum_c (csumNeg)
  );

  // Next-state and next-byte decode; every byte from HDR to the last payload
  // byte is added to the checksum as it is loaded into txData.
  always_comb begin
    stateNext   = state;
    countNext   = count;
    idxNext     = idx;
    typeNext    = pktType;
    txDataNext  = txData;
    txValidNext = txValid;
    pktSentNext = 1'b0;
    loadFrame   = 1'b0;
    storeWord   = 1'b0;
    csumClr     = 1'b0;
    csumAdd     = 1'b0;
    case (state)
      IDLE: begin
        if (!pktSent) begin
          case (bus.cmd)
            CMD_CTRL, CMD_VOICE: begin
              loadFrame = 1'b1;
              storeWord = 1'b1;
              csumClr   = 1'b1;
              countNext = CNT_W'(1);
              idxNext   = '0;
              typeNext  = (bus.cmd == CMD_CTRL) ? TYPE_CTRL : TYPE_VOICE;
              if (bus.cmd == CMD_CTRL || PKT_WORDS == 1) begin
                stateNext   = SYNC;
                txValidNext = 1'b1;
                txDataNext  = SYNC_BYTE;
              end else begin
                stateNext = COLLECT;
              end
            end
            CMD_IDLE, CMD_RSVD: ;
          endcase
        end
      end
      COLLECT: begin
        if (bus.cmd == CMD_VOICE) begin
          storeWord = 1'b1;
          countNext = count + CNT_W'(1);
        end
        if (bus.cmd != CMD_VOICE || count + CNT_W'(1) == LAST_CNT) begin
          stateNext   = SYNC;
          txValidNext = 1'b1;
          txDataNext  = SYNC_BYTE;
        end
      end
      SYNC: if (handshake) begin
        stateNext  = HDR;
        txDataNext = makeHdr(pktType, count);
        csumAdd    = 1'b1;
      end
      HDR: if (handshake) begin
        stateNext  = DST;
        txDataNext = phoneLatch;
        csumAdd    = 1'b1;
      end
      DST: if (handshake) begin
        stateNext  = SRC;
        txDataNext = selfLatch;
        csumAdd    = 1'b1;
      end
      SRC: if (handshake) begin
        stateNext  = PAY_HI;
        txDataNext = curWord[15:8];
        csumAdd    = 1'b1;
      end
      PAY_HI: if (handshake) begin
        stateNext  = PAY_LO;
        txDataNext = curWord[7:0];
        idxNext    = idx + CNT_W'(1);
        csumAdd    = 1'b1;
      end
      PAY_LO: if (handshake) begin
        if (idx == count) begin
          stateNext  = CSUM;
          txDataNext = csumNeg;
        end else begin
          stateNext  = PAY_HI;
          txDataNext = curWord[15:8];
          csumAdd    = 1'b1;
        end
      end
      CSUM: if (handshake) begin
        stateNext   = IDLE;
        txValidNext = 1'b0;
        pktSentNext = 1'b1;
        countNext   = '0;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      pktType <= '0;
      txData  <= '0;
      txValid <= 1'b0;
      pktSent <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= stateNext;
      count   <= countNext;
      idx     <= idxNext;
      pktType <= typeNext;
      txData  <= txDataNext;
      txValid <= txValidNext;
      pktSent <= pktSentNext;
      busy    <= (stateNext != IDLE) && (stateNext != COLLECT);
    end
  end

  // Frame addresses and payload words, captured while accepting.
  always_ff @(posedge clk) begin
    if (loadFrame) begin
      phoneLatch <= bus.phoneNum;
      selfLatch  <= bus.selfNum;
    end
    if (storeWord) begin
      wordBuf[IDX_W'(count)] <= bus.dataIn;
    end
  end

  // The checksum byte must bring the running sum back to zero.
  always_ff @(posedge clk) begin
    if (!reset && state == CSUM && handshake) begin
      assert (csumSum + txData == '0);
    end
  end

  assign bus.txData        = txData;
  assign bus.txValid       = txValid;
  assign bus.pktSent       = pktSent;
  assign bus.transportBusy = busy;

endmodule
